lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_LEN, default 14, byte-address width on the data-mux side.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum bus-wait cycles before abort.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rstb  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  core requests a memory operation.
REQ-007 req_ready  out  1  LSU idle and accepts a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  in  XLEN  byte address.
REQ-011 req_wdata  in  XLEN  store data, right-aligned.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  XLEN  extended load result; 0 for stores and errors.
REQ-014 rsp_err  out  1  qualifies rsp_valid: misaligned, illegal funct3, or timeout.
REQ-015 addr  out  ADDR_LEN  byte address to data mux.
REQ-016 rd_req / wr_req  out  1 each  bus read / write request, level-held.
REQ-017 rd_ready / wr_ready  in  1 each  bus completion.
REQ-018 be  out  XLEN/8  byte enables; wr_data  out  XLEN  lane-replicated store data.
REQ-019 rd_data  in  XLEN  read data, valid in the cycle rd_ready=1.

Function
REQ-020 SHALL implement FSM IDLE, RD, WR; req_ready=1 only in IDLE and rstb=1.
REQ-021 In IDLE, on req_valid=1, SHALL latch addr, funct3, offset=req_addr[1:0], be, and wr_data in one cycle.
REQ-022 SHALL flag an error for misalignment: H/HU with addr[0]=1, W with addr[1:0]!=0.
REQ-023 SHALL flag an error for illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
REQ-024 On error, SHALL stay in IDLE, issue no bus request, and pulse rsp_valid=1, rsp_err=1, rsp_rdata=0 on the next cycle.
REQ-025 Otherwise SHALL enter RD (load) or WR (store) next cycle.
REQ-026 In RD/WR, SHALL hold rd_req/wr_req=1 and keep addr/be/wr_data stable until completion.
REQ-027 addr SHALL be req_addr[ADDR_LEN-1:0], unmodified; upper bits are ignored.
REQ-028 be SHALL be: B 4'b0001<<off; H 4'b0011<<off; W 4'b1111.
REQ-029 wr_data SHALL be: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
REQ-030 For loads, be SHALL follow the same encoding.
REQ-031 In RD, a cycle with rd_ready=1 SHALL complete the load.
REQ-032 Load extraction SHALL shift rd_data right by 8*off, then sign-extend (B/H) or zero-extend (BU/HU); W is passed through.
REQ-033 In WR, a cycle with wr_ready=1 SHALL complete the store.
REQ-034 On completion, SHALL return to IDLE with rd_req/wr_req=0 at the next edge, and pulse rsp_valid=1, rsp_err=0 in that same next cycle.
REQ-035 Completion latency: request accepted at edge N, request visible N+1, ready at cycle K, rsp_valid at K+1.
REQ-036 A new request SHALL be accepted in the rsp_valid cycle (back-to-back).
REQ-037 SHALL count wait cycles in RD/WR, starting from 0 on entry.
REQ-038 When the count reaches TIMEOUT without ready, SHALL drop the request, return to IDLE, and pulse rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-039 Ready and timeout in the same cycle: ready SHALL win.
REQ-040 rd_ready/wr_ready in IDLE, or of the wrong type for the state, SHALL be ignored.
REQ-041 req_valid while not IDLE SHALL be ignored and not queued.

Reset
REQ-042 rstb=0 at an edge SHALL force IDLE, wait count 0, and all outputs 0 (req_ready=0, rd_req=wr_req=0, be=0, addr=0, wr_data=0, rsp_valid=0, rsp_err=0, rsp_rdata=0).
REQ-043 Reset mid-operation SHALL drop rd_req/wr_req at that edge with no rsp_valid; req_ready=1 in the first cycle after rstb=1.

Verification
REQ-044 SB addr 0x0103, wdata 0x000000A5, wr_ready after 2 cycles -> be=1000, wr_data=0xA5A5A5A5, one rsp_valid, err=0.
REQ-045 LB addr 0x0002, rd_data 0x00800000 -> rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x0002, rd_data 0xBEEF0000 -> 0x0000BEEF.
REQ-046 LW addr 0x0006 -> no rd_req, next cycle rsp_valid=1, err=1, rdata=0; store funct3=100 -> same error.
REQ-047 LW with rd_ready never asserted, TIMEOUT=255 -> rd_req high for 255 cycles, then rsp_valid=1, err=1; rd_ready on cycle 255 -> err=0.
REQ-048 rstb=0 while in WR -> wr_req=0 next cycle, no rsp_valid; after release, SW accepted and completes normally.
REQ-049 Back-to-back LW then SW with req_valid held -> second accepted in the first rsp_valid cycle; exactly two rsp_valid pulses.

Source files
------------

// File: rtl/lsu_if.sv
// Core-side request/response and data-mux-side bus signals of the load/store unit.
// slave = the LSU itself, master = whatever drives requests and answers the bus.
interface lsu_if #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic                 rsp_valid;
  logic [XLEN-1:0]      rsp_rdata;
  logic                 rsp_err;
  logic [ADDR_LEN-1:0]  addr;
  logic                 rd_req;
  logic                 wr_req;
  logic                 rd_ready;
  logic                 wr_ready;
  logic [XLEN/8-1:0]    be;
  logic [XLEN-1:0]      wr_data;
  logic [XLEN-1:0]      rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  rd_ready, wr_ready, rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output addr, rd_req, wr_req, be, wr_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output rd_ready, wr_ready, rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  addr, rd_req, wr_req, be, wr_data
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one request in flight, response pulse one cycle after bus ready, error or timeout.
// Accepts only when idle (no queueing); bus request is level-held until ready or TIMEOUT wait cycles.
module lsu #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14,
  parameter int TIMEOUT  = 255
) (
  input  logic  clk,
  input  logic  rstb,
  lsu_if.slave  bus
);
  localparam int NB = XLEN / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t               state;
  logic [CW-1:0]        wait_cnt;
  logic [2:0]           funct3_q;
  logic [1:0]           off_q;
  logic [ADDR_LEN-1:0]  addr_q;
  logic [NB-1:0]        be_q;
  logic [XLEN-1:0]      wr_data_q;
  logic [XLEN-1:0]      rsp_rdata_q;
  logic                 rd_req_q;
  logic                 wr_req_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;

  logic [1:0]           req_off;
  logic [1:0]           req_size;
  logic                 illegal;
  logic                 misalign;
  logic                 req_err;
  logic [NB-1:0]        be_nxt;
  logic [XLEN-1:0]      wr_data_nxt;
  logic [XLEN-1:0]      rd_shift;
  logic [XLEN-1:0]      load_data;
  logic                 unused_addr_hi;

  assign req_off  = bus.req_addr[1:0];
  assign req_size = bus.req_funct3[1:0];

  // Address bits above ADDR_LEN are intentionally dropped on the way to the mux.
  assign unused_addr_hi = ^bus.req_addr;

  always_comb begin
    illegal  = bus.req_we ? (bus.req_funct3[2] || req_size == 2'b11)
                          : (req_size == 2'b11 || bus.req_funct3[2:1] == 2'b11);
    misalign = (req_size == 2'b01 && req_off[0]) ||
               (req_size == 2'b10 && req_off != 2'b00);
    req_err  = illegal || misalign;
  end

  always_comb begin
    be_nxt      = '0;
    wr_data_nxt = bus.req_wdata;
    case (req_size)
      2'b00: begin
        be_nxt      = NB'(1) << req_off;
        wr_data_nxt = {NB{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_nxt      = NB'(3) << req_off;
        wr_data_nxt = {(NB/2){bus.req_wdata[15:0]}};
      end
      2'b10:   be_nxt = '1;
      default: be_nxt = '0;
    endcase
  end

  assign rd_shift = bus.rd_data >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wr_data_q   <= '0;
      rsp_rdata_q <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q  <= bus.req_funct3;
            off_q     <= req_off;
            addr_q    <= bus.req_addr[ADDR_LEN-1:0];
            be_q      <= be_nxt;
            wr_data_q <= wr_data_nxt;
            wait_cnt  <= '0;
            if (req_err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (bus.req_we) begin
              state    <= WR;
              wr_req_q <= 1'b1;
            end else begin
              state    <= RD;
              rd_req_q <= 1'b1;
            end
          end
        end
        RD: begin
          // Ready is tested before the wait limit so a last-cycle ready still succeeds.
          if (bus.rd_ready) begin
            state       <= IDLE;
            rd_req_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data;
          end else if (wait_cnt == LAST_WAIT) begin
            state       <= IDLE;
            rd_req_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        WR: begin
          if (bus.wr_ready) begin
            state       <= IDLE;
            wr_req_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
          end else if (wait_cnt == LAST_WAIT) begin
            state       <= IDLE;
            wr_req_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          rd_req_q <= 1'b0;
          wr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) && rstb;
  assign bus.rd_req    = rd_req_q;
  assign bus.wr_req    = wr_req_q;
  assign bus.addr      = addr_q;
  assign bus.be        = be_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for lsu against a transaction-level reference model.
module tb_lsu;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.XLEN(32), .ADDR_LEN(14)) bus ();

  lsu #(.XLEN(32), .ADDR_LEN(14), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- reference rules ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input bit we, input logic [2:0] f3);
    if (we) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [1:0] off);
    if (!legal(we, f3)) return 1'b1;
    return (int'(off) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
    int nb = nbytes(f3);
    if (nb > 4) return 4'd0;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int nb = nbytes(f3);
    if (nb > 4) nb = 4;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [31:0] s;
    int v;
    s = d >> (8 * int'(off));
    case (f3)
      3'd0: begin v = int'(s & 32'hFF);   if (v > 127)   v -= 256;   end
      3'd1: begin v = int'(s & 32'hFFFF); if (v > 32767) v -= 65536; end
      3'd4: v = int'(s & 32'hFF);
      3'd5: v = int'(s & 32'hFFFF);
      default: v = int'(d);
    endcase
    return 32'(v);
  endfunction

  // ---------------- model: one transaction at a time ----------------
  bit          model_ok = 0, m_busy = 0, m_store = 0, m_since_reset = 0;
  int          m_waits = 0;
  logic [2:0]  m_f3 = '0;
  logic [1:0]  m_off = '0;
  logic [13:0] m_addr = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_wd = '0;
  bit          e_valid = 0, e_err = 0;
  logic [31:0] e_rdata = '0;

  always @(posedge clk) begin
    e_valid = 0;
    e_err   = 0;
    e_rdata = '0;
    if (!rstb) begin
      model_ok = 1; m_busy = 0; m_waits = 0; m_since_reset = 1;
      m_addr = '0; m_be = '0; m_wd = '0;
    end else if (!m_busy) begin
      if (bus.req_valid) begin
        m_since_reset = 0;
        m_store = bus.req_we;
        m_f3    = bus.req_funct3;
        m_off   = bus.req_addr[1:0];
        m_addr  = bus.req_addr[13:0];
        m_be    = ref_be(bus.req_funct3, bus.req_addr[1:0]);
        m_wd    = ref_wd(bus.req_funct3, bus.req_wdata);
        m_waits = 0;
        if (ref_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
          e_valid = 1; e_err = 1;
        end else begin
          m_busy = 1;
        end
      end
    end else begin
      m_waits++;
      if (m_store ? bus.wr_ready : bus.rd_ready) begin
        m_busy  = 0;
        e_valid = 1;
        e_rdata = m_store ? 32'd0 : ref_load(m_f3, m_off, bus.rd_data);
      end else if (m_waits == TO) begin
        m_busy = 0; e_valid = 1; e_err = 1;
      end
    end
  end

  // ---------------- compare process + observation ----------------
  int          n_rsp = 0, busy_cycles = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0, last_wd = '0;
  logic [3:0]  last_be = '0;

  always @(negedge clk) begin
    if (model_ok) begin
      check("req_ready", bus.req_ready, !m_busy && rstb);
      check("rd_req",    bus.rd_req,    m_busy && !m_store);
      check("wr_req",    bus.wr_req,    m_busy && m_store);
      check("rsp_valid", bus.rsp_valid, e_valid);
      if (e_valid) begin
        check("rsp_err",   bus.rsp_err,   e_err);
        check("rsp_rdata", bus.rsp_rdata, e_rdata);
      end
      if (m_busy || m_since_reset) begin
        check("addr", bus.addr, m_addr);
        check("be",   bus.be,   m_be);
        if (m_store || m_since_reset) check("wr_data", bus.wr_data, m_wd);
      end
    end
    if (bus.rsp_valid === 1'b1) begin
      n_rsp++;
      last_err   = bus.rsp_err;
      last_rdata = bus.rsp_rdata;
    end
    if (bus.rd_req === 1'b1 || bus.wr_req === 1'b1) begin
      busy_cycles++;
      last_be = bus.be;
      last_wd = bus.wr_data;
    end
  end

  // ---------------- bus responder ----------------
  int          resp_delay = 1;
  int          rcnt = 0;
  bit          fixed_en = 0;
  logic [31:0] fixed_val = '0;

  always @(posedge clk) begin
    #1;
    if (bus.rd_req || bus.wr_req) rcnt++;
    else rcnt = 0;
    // Wrong-type and idle readies are random noise the LSU must ignore.
    bus.rd_ready = bus.rd_req ? (rcnt == resp_delay) : 1'($urandom_range(0, 1));
    bus.wr_ready = bus.wr_req ? (rcnt == resp_delay) : 1'($urandom_range(0, 1));
    bus.rd_data  = fixed_en ? fixed_val : 32'($urandom);
  end

  // ---------------- driver ----------------
  task automatic wait_accept(output logic rsp_at_accept);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) bound_expired("accept_wait");
    rsp_at_accept = bus.rsp_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (n_rsp < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n_rsp < target) bound_expired("rsp_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int dly);
    int start = n_rsp;
    logic ra;
    resp_delay  = dly;
    busy_cycles = 0;
    drive_req(we, f3, a, wd);
    wait_accept(ra);
    bus.req_valid = 1'b0;
    wait_rsp(start + 1);
  endtask

  logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s;
    logic ra;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.rd_ready = 0; bus.wr_ready = 0; bus.rd_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_rd_req",    bus.rd_req,    1'b0);
    check("rst_be",        bus.be,        4'h0);
    check("rst_rsp_err",   bus.rsp_err,   1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;

    // SB 0x0103, ready after 2 cycles
    s = n_rsp;
    txn(1'b1, 3'b000, 32'h0103, 32'h0000_00A5, 2);
    check("sb_be",        last_be,     4'b1000);
    check("sb_wr_data",   last_wd,     32'hA5A5_A5A5);
    check("sb_err",       last_err,    1'b0);
    check("sb_busy",      busy_cycles, 2);
    check("sb_rsp_count", n_rsp - s,   1);

    // Load extraction
    fixed_en = 1; fixed_val = 32'h0080_0000;
    txn(1'b0, 3'b000, 32'h0002, 32'h0, 1);
    check("lb_rdata", last_rdata, 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 32'h0002, 32'h0, 3);
    check("lbu_rdata", last_rdata, 32'h0000_0080);
    fixed_val = 32'hBEEF_0000;
    txn(1'b0, 3'b101, 32'h0002, 32'h0, 2);
    check("lhu_rdata", last_rdata, 32'h0000_BEEF);

    // Errors: misaligned LW, illegal store funct3
    txn(1'b0, 3'b010, 32'h0006, 32'h0, 1);
    check("lw_mis_busy",  busy_cycles, 0);
    check("lw_mis_err",   last_err,    1'b1);
    check("lw_mis_rdata", last_rdata,  32'h0);
    txn(1'b1, 3'b100, 32'h0010, 32'h1234, 1);
    check("st_ill_busy", busy_cycles, 0);
    check("st_ill_err",  last_err,    1'b1);

    // Timeout and ready on the last permitted cycle
    txn(1'b0, 3'b010, 32'h0040, 32'h0, -1);
    check("to_busy", busy_cycles, 255);
    check("to_err",  last_err,    1'b1);
    fixed_val = 32'h1357_9BDF;
    txn(1'b0, 3'b010, 32'h0044, 32'h0, 255);
    check("to_edge_busy",  busy_cycles, 255);
    check("to_edge_err",   last_err,    1'b0);
    check("to_edge_rdata", last_rdata,  32'h1357_9BDF);

    // Reset while in WR
    resp_delay = -1;
    drive_req(1'b1, 3'b010, 32'h0010, 32'h1234_5678);
    wait_accept(ra);
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    s = n_rsp;
    rstb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_wr_req",    bus.wr_req,    1'b0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_addr",      bus.addr,      14'h0);
    check("mid_rst_wr_data",   bus.wr_data,   32'h0);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", bus.req_ready, 1'b1);
    check("mid_rst_no_rsp",    n_rsp - s,     0);
    @(posedge clk); #1;
    txn(1'b1, 3'b010, 32'h0020, 32'hDEAD_BEEF, 3);
    check("after_rst_sw_err", last_err,  1'b0);
    check("after_rst_sw_wd",  last_wd,   32'hDEAD_BEEF);
    check("after_rst_sw_cnt", n_rsp - s, 1);

    // Back-to-back LW then SW with req_valid held
    resp_delay = 2;
    s = n_rsp;
    drive_req(1'b0, 3'b010, 32'h0030, 32'h0);
    wait_accept(ra);
    drive_req(1'b1, 3'b010, 32'h0034, 32'h1122_3344);
    wait_accept(ra);
    check("b2b_accept_in_rsp_cycle", ra, 1'b1);
    bus.req_valid = 1'b0;
    wait_rsp(s + 2);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_rsp_count", n_rsp - s, 2);

    // Randomized traffic
    fixed_en = 0;
    for (int i = 0; i < 300; i++) begin
      bit          we;
      logic [2:0]  f3;
      logic [31:0] a;
      int          dly;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8)
        f3 = we ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom);
      a   = 32'($urandom);
      dly = ($urandom_range(0, 39) == 0) ? -1 : int'($urandom_range(1, 6));
      txn(we, f3, a, 32'($urandom), dly);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
